// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle for the register-file write arbiter: two writeback request
// channels in, one registered write port plus hazard/status outputs.
interface regfile_write_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic              req0_valid;
  logic [AW-1:0]     req0_rd;
  logic [DW-1:0]     req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [AW-1:0]     req1_rd;
  logic [DW-1:0]     req1_data;
  logic              req1_ready;
  logic              writereg;
  logic [AW-1:0]     rd;
  logic [DW-1:0]     writedata;
  logic              grant;
  logic [2**AW-1:0]  pending;
  logic              busy;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output writereg, rd, writedata, grant, pending, busy
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  writereg, rd, writedata, grant, pending, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter (ALU = req 0, load = req 1) feeding the single
// register-file write port. Define WRARB_FIXED_PRIO_EN for fixed req-1 priority.
module regfile_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 8,
  parameter int AW    = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int             PW   = $clog2(DEPTH);
  localparam int             NREG = 2**AW;
  localparam logic [PW:0]    FULL = (PW+1)'(DEPTH);

  logic [1:0]      in_valid;
  logic [1:0]      ready;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      nonempty;
  logic [AW-1:0]   in_rd     [2];
  logic [DW-1:0]   in_data   [2];
  logic [AW-1:0]   head_rd   [2];
  logic [DW-1:0]   head_data [2];
  logic [NREG-1:0] fifo_pend [2];
  logic [NREG-1:0] pend_all;

  logic            vld_p0;
  logic            win_p0;
  logic [AW-1:0]   rd_p0;
  logic [DW-1:0]   data_p0;

  logic            vld_p1;
  logic            grant_p1;
  logic [AW-1:0]   rd_p1;
  logic [DW-1:0]   data_p1;

  assign in_valid   = {bus.req1_valid, bus.req0_valid};
  assign in_rd[0]   = bus.req0_rd;
  assign in_rd[1]   = bus.req1_rd;
  assign in_data[0] = bus.req0_data;
  assign in_data[1] = bus.req1_data;

  // Ready looks only at occupancy, so a full FIFO never passes a push through a same-cycle pop.
  assign push = in_valid & ready;

  for (genvar q = 0; q < 2; q++) begin : g_fifo
    logic [AW-1:0]   mem_rd   [DEPTH];
    logic [DW-1:0]   mem_data [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [NREG-1:0] pend;

    always_ff @(posedge clock) begin
      if (push[q]) begin
        mem_rd[wr_ptr]   <= in_rd[q];
        mem_data[wr_ptr] <= in_data[q];
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[q]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[q])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[q], pop[q]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
      logic [PW-1:0] off;
      pend = '0;
      off  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        off = PW'(i) - rd_ptr;
        if ({1'b0, off} < count) pend[mem_rd[i]] = 1'b1;
      end
    end

    assign ready[q]     = (count != FULL);
    assign nonempty[q]  = (count != '0);
    assign head_rd[q]   = mem_rd[rd_ptr];
    assign head_data[q] = mem_data[rd_ptr];
    assign fifo_pend[q] = pend;
  end

  // ---- stage p0: arbitrate over FIFO heads and pop the winner ----
`ifdef WRARB_FIXED_PRIO_EN
  assign win_p0 = nonempty[1];
`else
  logic rr_ptr;
  logic rr_adv;

  // Equal heads fall through to req 1 (older load first) without touching the pointer.
  always_comb begin
    win_p0 = nonempty[1];
    rr_adv = 1'b0;
    if ((nonempty == 2'b11) && (head_rd[0] != head_rd[1])) begin
      win_p0 = rr_ptr;
      rr_adv = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       rr_ptr <= 1'b0;
    else if (rr_adv) rr_ptr <= ~rr_ptr;
  end
`endif

  assign vld_p0  = |nonempty;
  assign pop     = vld_p0 ? (win_p0 ? 2'b10 : 2'b01) : 2'b00;
  assign rd_p0   = head_rd[win_p0];
  assign data_p0 = head_data[win_p0];

  // ---- stage p1: registered write port; rd 0 drains without a write strobe ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      grant_p1 <= 1'b0;
      rd_p1    <= '0;
      data_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0 && (rd_p0 != '0);
      if (vld_p0) begin
        grant_p1 <= win_p0;
        rd_p1    <= rd_p0;
        data_p1  <= data_p0;
      end
    end
  end

  assign pend_all       = fifo_pend[0] | fifo_pend[1];
  assign bus.pending    = {pend_all[NREG-1:1], 1'b0};
  assign bus.busy       = vld_p0;
  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.writereg   = vld_p1;
  assign bus.rd         = rd_p1;
  assign bus.writedata  = data_p1;
  assign bus.grant      = grant_p1;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (writereg/rd/writedata) between two writeback requesters: req 0 = ALU writeback, req 1 = load/memory writeback.
- Each requester has a small FIFO with a valid/ready handshake.
- A round-robin arbiter drains one entry per cycle into a registered write port.
- A pending-write bitmask is exported so ID hazard logic can stall reads of registers with queued writes.

Parameters:
- DEPTH, 2, entries per requester FIFO (power of two, >=2)
- DW, 8, write data width
- AW, 3, register address width (2**AW registers)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  ALU writeback request
- req0_rd  in  AW  destination register
- req0_data  in  DW  write data
- req0_ready  out  1  FIFO 0 can accept (not full)
- req1_valid  in  1  memory writeback request
- req1_rd  in  AW  destination register
- req1_data  in  DW  write data
- req1_ready  out  1  FIFO 1 can accept (not full)
- writereg  out  1  register file write enable (registered)
- rd  out  AW  register file write address (registered)
- writedata  out  DW  register file write data (registered)
- grant  out  1  requester that produced the current write (registered)
- pending  out  2**AW  bit r set while any buffered entry targets register r
- busy  out  1  either FIFO non-empty

Behaviour:
- Reset (async, active-high): FIFOs emptied, round-robin pointer = 0, writereg=0, rd=0, writedata=0, grant=0, pending=0, busy=0. req*_ready=1 once reset is low.
- Reset asserted mid-operation discards all queued entries; no write is issued on the cycle reset deasserts.
- Accept: an entry is pushed when reqN_valid & reqN_ready at a rising clock edge.
- reqN_ready is combinational from FIFO N occupancy only (count < DEPTH). It does not depend on the same-cycle pop, so no full-FIFO push+pop pass-through.
- Arbitration, each cycle, over FIFO heads:
  - Only one non-empty: that FIFO wins.
  - Both non-empty: winner = rr pointer; pointer then toggles to the other requester.
  - Pointer is updated only on a grant when both were eligible.
- Pop: the winner's head is popped. On the next edge: writereg=1, rd=head.rd, writedata=head.data, grant=winner.
- No FIFO non-empty: writereg=0; rd/writedata hold their last values.
- Latency: an entry accepted at edge N into an empty FIFO with no competition appears on writereg/rd/writedata after edge N+1 (one-cycle minimum).
- Register 0: entries with rd==0 are accepted and popped normally but produce writereg=0, and they never set pending[0].
- Ordering: FIFO order is preserved within a requester. Between requesters the order is arbitration order only.
- Same rd from both requesters in the same cycle: req 1 (memory) is written first, i.e. the older load, then the ALU result.
  - This tie-break overrides rr and does not move the pointer.
- pending is combinational from FIFO contents: OR over valid entries of one-hot(rd), excluding rd 0.
  - It clears the cycle after the last entry for that register pops.
- busy = FIFO0 non-empty | FIFO1 non-empty.
- Simultaneous push and pop on the same FIFO: count unchanged, and the head advances correctly.
- Pointer wrap at DEPTH is modulo DEPTH.

Optional Feature:
- Macro: WRARB_FIXED_PRIO_EN
- Defined: fixed priority, req 1 always beats req 0 when both are non-empty. The rr pointer is removed and the same-rd rule is subsumed. Req 0 may starve; that is accepted for in-order-load configurations.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset mid-stream: fill FIFO0 with rd=3/data=0x11 and rd=4/data=0x22, assert reset -> writereg=0, pending=0, busy=0 immediately; after release no write is issued.
- Single write latency: req0 push rd=5, data=0xA5 at edge N -> writereg=1, rd=5, writedata=0xA5, grant=0 after edge N+1; pending[5]=1 from edge N until the pop edge.
- Round-robin: hold both valid, req0 rd=1/rd=2, req1 rd=6/rd=7 -> writes in order 1 (pointer 0), 6, 2, 7 on consecutive cycles, with no idle cycle.
- Backpressure: DEPTH=2, push 3 entries to req1 while req0 keeps winning (fixed-prio off, pointer forced) -> req1_ready=0 when full, the third entry is held by the source and accepted after one pop, and no entry is lost or duplicated.
- rd 0: req0 push rd=0/data=0xFF -> popped after one cycle, writereg stays 0, pending[0] never set.
- Same-rd conflict: both push rd=3 in one cycle (req0 data=0x01, req1 data=0x02) -> first write 0x02 grant=1, then 0x01 grant=0; register 3 ends at 0x01.
